psum_drain: RTL and testbench
=============================

// Module: psum_drain
// PURPOSE
//  Output stage below the bottom row of the input-stationary MAC array.
//  Each column's final psum_out arrives one cycle after the column to its left.
//  This block de-skews those psums into aligned row vectors and buffers them in a small FIFO.
//  Rows drain over a valid/ready stream to the writeback path.
//  It issues stall_req so the array controller stops launching rows before the buffer overflows.
// PARAMETERS
//  NUM_COL     4   array columns (>=2)
//  PSUM_WIDTH  32  signed psum width per column
//  DEPTH       4   FIFO entries, power of 2, >=2
// PORTS
//  clk         in   1                     clock, rising edge
//  rst         in   1                     synchronous, active-high reset
//  row_valid   in   1                     row's column-0 psum valid this cycle
//  psum_in     in   NUM_COL*PSUM_WIDTH    col c at [c*PSUM_WIDTH +: PSUM_WIDTH]
//  stall_req   out  1                     upstream must not assert row_valid next cycle
//  out_valid   out  1                     FIFO head holds an aligned row
//  out_ready   in   1                     consumer accepts head this cycle
//  out_data    out  NUM_COL*PSUM_WIDTH    aligned row, same column packing as psum_in
//  fifo_level  out  $clog2(DEPTH+1)       rows stored in FIFO
//  overflow    out  1                     sticky: a row was dropped
// BEHAVIOUR
//  - Row r with row_valid at cycle t: column c is valid on psum_in at cycle t+c.
//  - This timing is exact; the block never waits for late columns.
//  - Deskew: column c is delayed NUM_COL-1-c cycles through per-column shift registers.
//  - row_valid is delayed NUM_COL-1 cycles through a valid shift register.
//  - All shift registers advance every cycle and are unaffected by the FIFO state.
//  - Push: the aligned row is written into the FIFO at the clock edge ending cycle t+NUM_COL-1.
//  - Latency: out_valid=1 at cycle t+NUM_COL when the FIFO was empty.
//  - Back-to-back rows (row_valid every cycle) are supported at 1 row/cycle.
//  - FIFO: first-word fall-through; out_data = mem[rd_ptr]; out_valid = (fifo_level!=0).
//  - Pop when out_valid & out_ready. Pointers wrap modulo DEPTH.
//  - Push is accepted if fifo_level<DEPTH, or if a pop happens in the same cycle.
//  - Simultaneous push+pop: level is unchanged, pointers both advance.
//  - Push when full with no pop: row dropped, FIFO unchanged, overflow<=1 until rst.
//  - stall_req = (fifo_level + inflight) >= DEPTH - 1, where inflight = popcount of the valid shift register.
//  - stall_req is combinational from registers only, with no path from row_valid or out_ready.
//  - Arithmetic: psums pass bit-exact with no sign extension or saturation.
//  - level is PSUM-independent, and fifo_level width holds the value DEPTH.
//  - Reset (any cycle, including mid-flight) clears the shift registers, valid bits, pointers, mem, level and overflow.
//  - Next cycle after rst: out_valid=0, out_data=0, fifo_level=0, stall_req=0, overflow=0.
//  - In-flight rows are discarded on reset.
//  - row_valid and psum_in are ignored while rst=1.
//  - out_data is 0 while the FIFO is empty only after reset; otherwise it is don't-care when out_valid=0.
// TESTING
//  Cycle numbers are relative to each scenario's stimulus.
//  1 Single row, NUM_COL=4: row_valid@0; col c = 32'h100+c driven @c.
//    Required: out_valid@4, out_data={103,102,101,100}; pop -> level 0.
//  2 4 rows back-to-back (@0..3), col c of row r = r*16+c, out_ready=1.
//    Required: beats @4..7, in order, no bubbles, overflow=0.
//  3 DEPTH=4, out_ready=0: rows @0,1,2.
//    Required: stall_req=1 from cycle 3; a row forced @3 fills the FIFO (level 4).
//    A row forced @4 sets overflow=1 @8 with level still 4.
//  4 FIFO full, out_ready=1 on the same cycle a row is pushed.
//    Required: level stays 4, overflow stays 0, next head = 2nd-oldest row.
//  5 rst pulse @2 with rows launched @0,1.
//    Required: @3 out_valid=0, level=0, stall_req=0; no beat ever appears.
//  6 Sign/extremes: col0=32'h80000000, col1=32'hFFFFFFFF, col2=0, col3=32'h7FFFFFFF.
//    Required: identical bits on out_data.

Source files
------------

// File: rtl/psum_drain.sv
// psum_drain: de-skews per-column psums into aligned rows and buffers them in a FWFT FIFO.
module psum_drain #(
    parameter int NUM_COL    = 4,
    parameter int PSUM_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          row_valid,
    input  logic [NUM_COL*PSUM_WIDTH-1:0] psum_in,
    output logic                          stall_req,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_COL*PSUM_WIDTH-1:0] out_data,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_level,
    output logic                          overflow
);
    localparam int W  = NUM_COL * PSUM_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(DEPTH + NUM_COL + 1);

    logic [W-1:0]         aligned;
    logic [NUM_COL-2:0]   vsr;
    logic [W-1:0]         mem [DEPTH];
    logic [AW-1:0]        rd_ptr, wr_ptr;
    logic                 pop, push;

    // Column c arrives c cycles late, so it is held NUM_COL-1-c cycles to line up with the last column.
    genvar c;
    generate
        for (c = 0; c < NUM_COL; c++) begin : g_col
            localparam int D = NUM_COL - 1 - c;
            if (D == 0) begin : g_pass
                assign aligned[c*PSUM_WIDTH +: PSUM_WIDTH] = psum_in[c*PSUM_WIDTH +: PSUM_WIDTH];
            end else begin : g_dly
                logic [PSUM_WIDTH-1:0] sr [D];
                always_ff @(posedge clk) begin
                    if (rst) begin
                        for (int k = 0; k < D; k++) sr[k] <= '0;
                    end else begin
                        sr[0] <= psum_in[c*PSUM_WIDTH +: PSUM_WIDTH];
                        for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
                    end
                end
                assign aligned[c*PSUM_WIDTH +: PSUM_WIDTH] = sr[D-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            vsr <= '0;
        end else begin
            vsr[0] <= row_valid;
            for (int k = 1; k < NUM_COL - 1; k++) vsr[k] <= vsr[k-1];
        end
    end

    assign out_valid = fifo_level != '0;
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push      = vsr[NUM_COL-2] & ((fifo_level < LW'(DEPTH)) | pop);
    // Counting rows still in the deskew pipe keeps room for everything already launched.
    assign stall_req = (CW'(fifo_level) + CW'($countones(vsr))) >= CW'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= aligned;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            if (vsr[NUM_COL-2] & ~push) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed scenarios plus random traffic against a queue-based row model.
module tb_psum_drain;
    localparam int NC = 4, PW = 32, D = 4, W = NC * PW, LW = $clog2(D + 1), MAXC = 4096;

    logic clk = 1'b0;
    logic rst, row_valid, out_ready, stall_req, out_valid, overflow;
    logic [W-1:0] psum_in, out_data;
    logic [LW-1:0] fifo_level;

    psum_drain #(.NUM_COL(NC), .PSUM_WIDTH(PW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .row_valid(row_valid), .psum_in(psum_in),
        .stall_req(stall_req), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0, n_cmp = 0, n_bad = 0;
    bit launch [MAXC];
    logic [W-1:0] rowd [MAXC];
    logic [W-1:0] q [$];
    bit m_ovf = 1'b0, fresh = 1'b1;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mkrow(input logic [PW-1:0] base);
        logic [W-1:0] r;
        for (int c = 0; c < NC; c++) r[c*PW +: PW] = base + PW'(c);
        return r;
    endfunction

    // One clock cycle: drive at edge+1, check model expectations at edge+4, then update the model.
    task automatic step(input bit r, input bit rv, input logic [W-1:0] d, input bit rdy);
        int infl, k;
        bit pop;
        rst = r; row_valid = rv; out_ready = rdy;
        launch[cyc] = rv && !r;
        rowd[cyc] = d;
        for (int c = 0; c < NC; c++) begin
            k = cyc - c;
            psum_in[c*PW +: PW] = (k >= 0 && launch[k]) ? rowd[k][c*PW +: PW] : PW'($urandom);
        end
        #3;
        if (!r) begin
            infl = 0;
            for (int j = 1; j < NC; j++) if (cyc - j >= 0 && launch[cyc-j]) infl++;
            check("level", W'(fifo_level), W'(q.size()));
            check("valid", W'(out_valid), W'(q.size() != 0));
            if (q.size() != 0) check("data", out_data, q[0]);
            else if (fresh) check("data_rst", out_data, '0);
            check("stall", W'(stall_req), W'((q.size() + infl) >= D - 1));
            check("overflow", W'(overflow), W'(m_ovf));
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
            fresh = 1'b1;
            for (int j = cyc - NC; j <= cyc; j++) if (j >= 0) launch[j] = 1'b0;
        end else begin
            pop = (q.size() != 0) && rdy;
            if (pop) void'(q.pop_front());
            k = cyc - (NC - 1);
            if (k >= 0 && launch[k]) begin
                if (q.size() < D) begin
                    q.push_back(rowd[k]);
                    fresh = 1'b0;
                end else m_ovf = 1'b1;
            end
        end
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
    endtask

    logic [W-1:0] ext;

    initial begin
        // 1: single row latency and packing
        do_reset();
        step(0, 1, mkrow(32'h100), 0);
        repeat (3) step(0, 0, '0, 0);
        check("s1_valid", W'(out_valid), W'(1));
        check("s1_data", out_data, 128'h00000103_00000102_00000101_00000100);
        step(0, 0, '0, 1);
        check("s1_level", W'(fifo_level), W'(0));

        // 2: back-to-back rows drain with no bubbles
        do_reset();
        for (int r = 0; r < 4; r++) step(0, 1, mkrow(PW'(r * 16)), 1);
        for (int r = 0; r < 4; r++) begin
            check("s2_valid", W'(out_valid), W'(1));
            check("s2_data", out_data, mkrow(PW'(r * 16)));
            step(0, 0, '0, 1);
        end
        check("s2_ovf", W'(overflow), W'(0));

        // 3: stall and overflow
        do_reset();
        for (int r = 0; r < 3; r++) step(0, 1, mkrow(PW'(32'h300 + r * 16)), 0);
        check("s3_stall", W'(stall_req), W'(1));
        step(0, 1, mkrow(32'h330), 0);
        step(0, 1, mkrow(32'h340), 0);
        repeat (2) step(0, 0, '0, 0);
        check("s3_full", W'(fifo_level), W'(4));
        check("s3_noovf", W'(overflow), W'(0));
        step(0, 0, '0, 0);
        check("s3_ovf", W'(overflow), W'(1));
        check("s3_level", W'(fifo_level), W'(4));

        // 4: push into a full FIFO while popping
        do_reset();
        for (int r = 0; r < 5; r++) step(0, 1, mkrow(PW'(32'h400 + r * 16)), 0);
        repeat (2) step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        check("s4_level", W'(fifo_level), W'(4));
        check("s4_ovf", W'(overflow), W'(0));
        check("s4_head", out_data, mkrow(32'h410));

        // 5: reset mid-flight discards rows
        do_reset();
        step(0, 1, mkrow(32'h500), 1);
        step(0, 1, mkrow(32'h510), 1);
        step(1, 0, '0, 1);
        check("s5_valid", W'(out_valid), W'(0));
        check("s5_level", W'(fifo_level), W'(0));
        check("s5_stall", W'(stall_req), W'(0));
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1);
        check("s5_never", W'(out_valid), W'(0));

        // 6: extreme values pass bit-exact
        do_reset();
        ext = 128'h7FFFFFFF_00000000_FFFFFFFF_80000000;
        step(0, 1, ext, 0);
        repeat (3) step(0, 0, '0, 0);
        check("s6_data", out_data, ext);

        // random traffic, mostly honouring stall_req, with occasional resets
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bit rv;
            rv = stall_req ? ($urandom_range(7) == 0) : $urandom_range(1) == 1;
            step($urandom_range(99) == 0, rv, {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
